reorder_buffer: RTL and testbench

//  In-order retirement queue feeding the flag-status tracker and register rename logic.
//  - Allocates one entry per dispatched instruction and publishes the allocated tag on ROBTail.
//  - Captures results broadcast on the CDB and retires entries strictly in program order.
//  - CDB tag field is the ROB entry index.

---
 rtl/reorder_buffer_if.sv | 37 +++
 rtl/reorder_buffer.sv | 127 ++++++++++++
 tb/tb_reorder_buffer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Reorder buffer port bundle: dispatch/append, CDB broadcast, flush, and the
// in-order commit stream.
//   slave  : the reorder buffer (consumes append/CDB/flush/ack, drives commit side)
//   master : the surrounding pipeline (drives append/CDB/flush/ack, observes commit side)
interface reorder_buffer_if #(
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DEST_W = 5,
  parameter int unsigned PAY_W  = 144
);
  localparam int unsigned CDB_W = PAY_W + TAG_W + 1;

  logic              append;
  logic              S;
  logic [DEST_W-1:0] append_dest;
  logic [CDB_W-1:0]  CDB;
  logic              flush;
  logic              commit_ack;

  logic [TAG_W-1:0]  ROBTail;
  logic              full;
  logic              empty;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic [DEST_W-1:0] commit_dest;
  logic              commit_S;
  logic [PAY_W-1:0]  commit_data;

  modport slave (
    input  append, S, append_dest, CDB, flush, commit_ack,
    output ROBTail, full, empty, commit_valid, commit_tag, commit_dest, commit_S, commit_data
  );

  modport master (
    output append, S, append_dest, CDB, flush, commit_ack,
    input  ROBTail, full, empty, commit_valid, commit_tag, commit_dest, commit_S, commit_data
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue. Allocates one entry per dispatched instruction
// (tag published on ROBTail), captures results from the CDB by tag, and
// retires entries strictly in program order under a valid/ack handshake.
// Ports:
//   CLK   : clock, all state on the rising edge
//   Reset : asynchronous, active-high
//   rob   : reorder_buffer_if.slave (append/S/append_dest/CDB/flush/commit_ack in;
//           ROBTail/full/empty/commit_* out, combinational from registered state)
module reorder_buffer #(
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DEST_W = 5,
  parameter int unsigned PAY_W  = 144
) (
  input  logic             CLK,
  input  logic             Reset,
  reorder_buffer_if.slave  rob
);
  localparam int unsigned DEPTH = 1 << TAG_W;
  localparam int unsigned CNT_W = TAG_W + 1;
  localparam int unsigned CDB_W = PAY_W + TAG_W + 1;

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [DEPTH-1:0]  s_q, s_d;
  logic [DEST_W-1:0] dest_q [DEPTH];
  logic [DEST_W-1:0] dest_d [DEPTH];
  logic [PAY_W-1:0]  data_q [DEPTH];
  logic [PAY_W-1:0]  data_d [DEPTH];

  logic              full_c;
  logic              commit_valid_c;
  logic              append_acc_c;
  logic              commit_acc_c;
  logic              cdb_valid_c;
  logic [TAG_W-1:0]  cdb_tag_c;
  logic [PAY_W-1:0]  cdb_pay_c;

  // CDB field split: valid on top, tag below it, opaque payload at the bottom
  assign cdb_valid_c = rob.CDB[CDB_W-1];
  assign cdb_tag_c   = rob.CDB[PAY_W +: TAG_W];
  assign cdb_pay_c   = rob.CDB[PAY_W-1:0];

  assign full_c         = (count_q == CNT_W'(DEPTH));
  assign commit_valid_c = busy_q[head_q] & ready_q[head_q];
  // full blocks append even when a commit frees a slot this cycle
  assign append_acc_c   = rob.append & ~full_c & ~rob.flush;
  assign commit_acc_c   = commit_valid_c & rob.commit_ack & ~rob.flush;

  // Outputs from registered state only
  assign rob.ROBTail      = tail_q;
  assign rob.full         = full_c;
  assign rob.empty        = (count_q == '0);
  assign rob.commit_valid = commit_valid_c;
  assign rob.commit_tag   = head_q;
  assign rob.commit_dest  = dest_q[head_q];
  assign rob.commit_S     = s_q[head_q];
  assign rob.commit_data  = data_q[head_q];

  // Next-state: CDB capture, then allocation (wins on tag clash), then retirement
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    s_d     = s_q;
    dest_d  = dest_q;
    data_d  = data_q;

    if (rob.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = '0;
      ready_d = '0;
    end else begin
      if (cdb_valid_c && busy_q[cdb_tag_c] && !ready_q[cdb_tag_c]) begin
        data_d[cdb_tag_c]  = cdb_pay_c;
        ready_d[cdb_tag_c] = 1'b1;
      end

      if (append_acc_c) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        s_d[tail_q]     = rob.S;
        dest_d[tail_q]  = rob.append_dest;
        tail_d          = tail_q + TAG_W'(1);
      end

      if (commit_acc_c) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + TAG_W'(1);
      end

      count_d = count_q + CNT_W'(append_acc_c) - CNT_W'(commit_acc_c);
    end
  end

  // State registers; Reset clears everything including stored payloads
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      ready_q <= '0;
      s_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      s_q     <= s_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: scenario tasks plus a commit
// scoreboard fed at append time and drained when the DUT retires.
module tb_reorder_buffer;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned DEST_W = 5;
  localparam int unsigned PAY_W  = 144;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DEST_W-1:0] dest;
    logic              s;
  } exp_t;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  reorder_buffer_if #(.TAG_W(TAG_W), .DEST_W(DEST_W), .PAY_W(PAY_W)) rob ();
  reorder_buffer #(.TAG_W(TAG_W), .DEST_W(DEST_W), .PAY_W(PAY_W)) dut (
    .CLK(CLK), .Reset(Reset), .rob(rob)
  );

  exp_t             sb_q[$];
  logic [PAY_W-1:0] exp_data [8];
  int checks   = 0;
  int failures = 0;
  int retired  = 0;

  // Retirement monitor: every accepted commit must match the oldest expected entry
  always @(negedge CLK) begin
    exp_t e;
    if (!Reset && rob.commit_valid && rob.commit_ack && !rob.flush) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected: got tag=%0d, none expected", rob.commit_tag);
      end else begin
        e = sb_q.pop_front();
        retired++;
        if (rob.commit_tag !== e.tag || rob.commit_dest !== e.dest ||
            rob.commit_S !== e.s || rob.commit_data !== exp_data[e.tag]) begin
          failures++;
          $display("FAIL commit_order: got tag=%0d dest=%0d S=%0b data=%0h, expected tag=%0d dest=%0d S=%0b data=%0h",
                   rob.commit_tag, rob.commit_dest, rob.commit_S, rob.commit_data,
                   e.tag, e.dest, e.s, exp_data[e.tag]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    rob.append      = 1'b0;
    rob.S           = 1'b0;
    rob.append_dest = '0;
    rob.CDB         = '0;
    rob.flush       = 1'b0;
    rob.commit_ack  = 1'b0;
  endtask

  task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [PAY_W-1:0] pay);
    rob.CDB = {1'b1, tag, pay};
  endtask

  // Drive one accepted append for a cycle, checking the tag shown while it is asserted
  task automatic append_one(input logic [TAG_W-1:0] exp_tag, input logic [DEST_W-1:0] dest,
                            input logic s);
    exp_t e;
    rob.append = 1'b1; rob.append_dest = dest; rob.S = s;
    checks++;
    if (rob.ROBTail !== exp_tag) begin
      failures++; $display("FAIL append_tag: got %0d expected %0d", rob.ROBTail, exp_tag);
    end
    e.tag = exp_tag; e.dest = dest; e.s = s;
    sb_q.push_back(e);
    cyc();
    rob.append = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1'b1;
    cyc(); cyc();
    Reset = 1'b0;
    checks++;
    if (rob.ROBTail !== 3'd0 || rob.empty !== 1'b1 || rob.full !== 1'b0 || rob.commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: got tail=%0d empty=%0b full=%0b cv=%0b expected 0 1 0 0",
               rob.ROBTail, rob.empty, rob.full, rob.commit_valid);
    end
    checks++;
    if (rob.commit_tag !== '0 || rob.commit_dest !== '0 || rob.commit_S !== 1'b0 || rob.commit_data !== '0) begin
      failures++;
      $display("FAIL reset_commit_fields: got tag=%0d dest=%0d S=%0b data=%0h expected all 0",
               rob.commit_tag, rob.commit_dest, rob.commit_S, rob.commit_data);
    end
  endtask

  task automatic test_append();
    append_one(3'd0, 5'd1, 1'b0);
    append_one(3'd1, 5'd2, 1'b1);
    append_one(3'd2, 5'd3, 1'b0);
    checks++;
    if (rob.ROBTail !== 3'd3 || dut.count_q !== 4'd3 || rob.empty !== 1'b0 || rob.commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL append_three: got tail=%0d count=%0d empty=%0b cv=%0b expected 3 3 0 0",
               rob.ROBTail, dut.count_q, rob.empty, rob.commit_valid);
    end
  endtask

  task automatic test_out_of_order_cdb();
    rob.commit_ack = 1'b1;
    exp_data[1] = PAY_W'(144'hA);
    set_cdb(3'd1, PAY_W'(144'hA));
    cyc();
    checks++;
    if (rob.commit_valid !== 1'b0) begin
      failures++; $display("FAIL cdb_nonhead: got cv=%0b expected 0", rob.commit_valid);
    end
    exp_data[0] = PAY_W'(144'hB);
    set_cdb(3'd0, PAY_W'(144'hB));
    cyc();
    rob.CDB = '0;
    checks++;
    if (rob.commit_valid !== 1'b1 || rob.commit_tag !== 3'd0) begin
      failures++; $display("FAIL cdb_head_ready: got cv=%0b tag=%0d expected 1 0", rob.commit_valid, rob.commit_tag);
    end
    cyc();
    checks++;
    if (rob.commit_valid !== 1'b1 || rob.commit_tag !== 3'd1 || rob.commit_S !== 1'b1) begin
      failures++;
      $display("FAIL retire_second: got cv=%0b tag=%0d S=%0b expected 1 1 1", rob.commit_valid, rob.commit_tag, rob.commit_S);
    end
    cyc();
    rob.commit_ack = 1'b0;
    checks++;
    if (rob.commit_valid !== 1'b0 || rob.commit_tag !== 3'd2 || retired !== 2) begin
      failures++;
      $display("FAIL retire_done: got cv=%0b tag=%0d retired=%0d expected 0 2 2", rob.commit_valid, rob.commit_tag, retired);
    end
  endtask

  task automatic test_full_wrap();
    exp_t e;
    rob.flush = 1'b1; cyc(); rob.flush = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 8; i++) append_one(3'(i), 5'(8 + i), 1'(i));
    checks++;
    if (rob.full !== 1'b1 || rob.ROBTail !== 3'd0 || dut.count_q !== 4'd8) begin
      failures++;
      $display("FAIL fill: got full=%0b tail=%0d count=%0d expected 1 0 8", rob.full, rob.ROBTail, dut.count_q);
    end
    rob.append = 1'b1; rob.append_dest = 5'd31;
    cyc();
    rob.append = 1'b0;
    checks++;
    if (rob.full !== 1'b1 || rob.ROBTail !== 3'd0 || dut.count_q !== 4'd8) begin
      failures++;
      $display("FAIL append_when_full: got full=%0b tail=%0d count=%0d expected 1 0 8", rob.full, rob.ROBTail, dut.count_q);
    end
    exp_data[0] = PAY_W'(144'h100);
    set_cdb(3'd0, PAY_W'(144'h100));
    cyc();
    rob.CDB = '0;
    // commit and append together while full: only the commit takes effect
    rob.commit_ack = 1'b1; rob.append = 1'b1; rob.append_dest = 5'd31;
    cyc();
    rob.commit_ack = 1'b0; rob.append = 1'b0;
    checks++;
    if (rob.full !== 1'b0 || rob.ROBTail !== 3'd0 || dut.count_q !== 4'd7 || retired !== 3) begin
      failures++;
      $display("FAIL commit_blocks_full_append: got full=%0b tail=%0d count=%0d retired=%0d expected 0 0 7 3",
               rob.full, rob.ROBTail, dut.count_q, retired);
    end
    append_one(3'd0, 5'd30, 1'b0);
    checks++;
    if (rob.full !== 1'b1 || rob.ROBTail !== 3'd1 || dut.count_q !== 4'd8) begin
      failures++;
      $display("FAIL wrap_append: got full=%0b tail=%0d count=%0d expected 1 1 8", rob.full, rob.ROBTail, dut.count_q);
    end
    e.tag = 0;
  endtask

  task automatic test_stray_cdb();
    rob.flush = 1'b1; cyc(); rob.flush = 1'b0;
    sb_q.delete();
    set_cdb(3'd5, PAY_W'(144'h55));
    cyc();
    rob.CDB = '0;
    checks++;
    if (rob.empty !== 1'b1 || rob.ROBTail !== 3'd0 || dut.busy_q !== 8'h00 || dut.ready_q !== 8'h00) begin
      failures++;
      $display("FAIL stray_cdb: got empty=%0b tail=%0d busy=%0h ready=%0h expected 1 0 0 0",
               rob.empty, rob.ROBTail, dut.busy_q, dut.ready_q);
    end
    for (int i = 0; i < 5; i++) append_one(3'(i), 5'(20 + i), 1'b0);
    // allocation and CDB hit tag 5 in the same cycle: allocation wins
    set_cdb(3'd5, PAY_W'(144'h77));
    append_one(3'd5, 5'd25, 1'b0);
    rob.CDB = '0;
    checks++;
    if (dut.busy_q[5] !== 1'b1 || dut.ready_q[5] !== 1'b0 || dut.count_q !== 4'd6) begin
      failures++;
      $display("FAIL alloc_wins: got busy5=%0b ready5=%0b count=%0d expected 1 0 6",
               dut.busy_q[5], dut.ready_q[5], dut.count_q);
    end
  endtask

  task automatic test_back_to_back();
    exp_data[0] = PAY_W'(144'hC0);
    set_cdb(3'd0, PAY_W'(144'hC0));
    cyc();
    rob.CDB = '0;
    rob.commit_ack = 1'b1;
    append_one(3'd6, 5'd7, 1'b1);
    rob.commit_ack = 1'b0;
    checks++;
    if (dut.count_q !== 4'd6 || rob.ROBTail !== 3'd7 || rob.commit_tag !== 3'd1 ||
        rob.commit_valid !== 1'b0 || retired !== 4) begin
      failures++;
      $display("FAIL commit_and_append: got count=%0d tail=%0d head=%0d cv=%0b retired=%0d expected 6 7 1 0 4",
               dut.count_q, rob.ROBTail, rob.commit_tag, rob.commit_valid, retired);
    end
  endtask

  task automatic test_flush_and_reset();
    exp_data[1] = PAY_W'(144'hD1);
    set_cdb(3'd1, PAY_W'(144'hD1));
    cyc();
    checks++;
    if (rob.commit_valid !== 1'b1) begin
      failures++; $display("FAIL pre_flush_ready: got cv=%0b expected 1", rob.commit_valid);
    end
    rob.flush = 1'b1; rob.append = 1'b1; rob.append_dest = 5'd9;
    rob.commit_ack = 1'b1; set_cdb(3'd2, PAY_W'(144'hE2));
    cyc();
    clear_inputs();
    sb_q.delete();
    checks++;
    if (rob.empty !== 1'b1 || rob.ROBTail !== 3'd0 || rob.commit_valid !== 1'b0 ||
        dut.count_q !== 4'd0 || dut.busy_q !== 8'h00 || retired !== 4) begin
      failures++;
      $display("FAIL flush: got empty=%0b tail=%0d cv=%0b count=%0d busy=%0h retired=%0d expected 1 0 0 0 0 4",
               rob.empty, rob.ROBTail, rob.commit_valid, dut.count_q, dut.busy_q, retired);
    end
    append_one(3'd0, 5'd11, 1'b0);
    append_one(3'd1, 5'd12, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (rob.empty !== 1'b1 || rob.ROBTail !== 3'd0 || dut.count_q !== 4'd0 || dut.busy_q !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: got empty=%0b tail=%0d count=%0d busy=%0h expected 1 0 0 0",
               rob.empty, rob.ROBTail, dut.count_q, dut.busy_q);
    end
    sb_q.delete();
    cyc();
    Reset = 1'b0;
    cyc();
  endtask

  initial begin
    Reset = 1'b1;
    clear_inputs();
    test_reset();
    test_append();
    test_out_of_order_cdb();
    test_full_wrap();
    test_stray_cdb();
    test_back_to_back();
    test_flush_and_reset();
    checks++;
    if (retired !== 4) begin
      failures++; $display("FAIL total_retired: got %0d expected 4", retired);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
